// File: rtl/alu_if.sv
// alu_if: operand, opcode and result bundle between the host and the alu.
interface alu_if;
    logic [31:0] inputP;
    logic [31:0] inputQ;
    logic [3:0]  opCode;
    logic [31:0] outALU;
    logic [1:0]  errorCode;
    modport master (output inputP, inputQ, opCode, input outALU, errorCode);
    modport slave (input inputP, inputQ, opCode, output outALU, errorCode);
endinterface

// File: rtl/alu.sv
// alu: registered 32-bit unsigned ALU with a per-operation 2-bit status.
// One operation per rising edge; rst_n clears result and status asynchronously.
module alu (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    logic [32:0] sum;
    logic [63:0] prod;
    logic        qZero;
    logic [31:0] outReg;
    logic [31:0] nextOut;
    logic [1:0]  errReg;
    logic [1:0]  nextErr;
    assign sum   = {1'b0, bus.inputP} + {1'b0, bus.inputQ};
    assign prod  = {32'd0, bus.inputP} * {32'd0, bus.inputQ};
    assign qZero = bus.inputQ == 32'd0;
    // Every opcode yields a defined value so reserved codes never propagate X.
    always_comb begin
        nextOut = outReg;
        nextErr = 2'b00;
        case (bus.opCode)
            4'h1: begin
                nextOut = sum[31:0];
                nextErr = {1'b0, sum[32]};
            end
            4'h2: begin
                nextOut = bus.inputP - bus.inputQ;
                nextErr = {1'b0, bus.inputP < bus.inputQ};
            end
            4'h3: begin
                nextOut = prod[31:0];
                nextErr = {1'b0, |prod[63:32]};
            end
            4'h4: begin
                nextOut = qZero ? 32'd0 : bus.inputP / bus.inputQ;
                nextErr = qZero ? 2'b10 : 2'b00;
            end
            4'h5: begin
                nextOut = qZero ? 32'd0 : bus.inputP % bus.inputQ;
                nextErr = qZero ? 2'b10 : 2'b00;
            end
            4'h6: nextOut = bus.inputP & bus.inputQ;
            4'h7: nextOut = bus.inputP | bus.inputQ;
            4'h8: nextOut = bus.inputP ^ bus.inputQ;
            4'h9: nextOut = ~bus.inputP;
            4'hA: nextOut = bus.inputP << bus.inputQ[4:0];
            4'hB: nextOut = bus.inputP >> bus.inputQ[4:0];
            4'hC: nextOut = 32'd0;
            4'hD: nextOut = bus.inputP;
            4'hE, 4'hF: nextErr = 2'b11;
            default: nextErr = 2'b00;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outReg <= 32'd0;
            errReg <= 2'b00;
        end else begin
            outReg <= nextOut;
            errReg <= nextErr;
        end
    end
    assign bus.outALU    = outReg;
    assign bus.errorCode = errReg;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu; expectations queued at drive time, popped after the edge.
module tb_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [33:0] expQ[$];
    alu_if bus();
    alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic popCheck(input string tag);
        logic [33:0] e;
        if (expQ.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        check({tag, ".out"}, bus.outALU, e[33:2]);
        check({tag, ".err"}, {30'd0, bus.errorCode}, {30'd0, e[1:0]});
    endtask
    task automatic drive(input string tag, input logic [3:0] op, input logic [31:0] p, input logic [31:0] q,
                         input logic [31:0] eo, input logic [1:0] ee);
        @(negedge clk);
        bus.opCode = op;
        bus.inputP = p;
        bus.inputQ = q;
        expQ.push_back({eo, ee});
        @(posedge clk);
        #1;
        popCheck(tag);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] p;
        logic [31:0] q;
        bus.opCode = 4'hD;
        bus.inputP = 32'hDEAD;
        bus.inputQ = 32'd0;
        #3 rst_n = 1'b0;
        #1;
        check("rst.out", bus.outALU, 32'd0);
        check("rst.err", {30'd0, bus.errorCode}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rstHold.out", bus.outALU, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        drive("firstLoad", 4'hD, 32'hDEAD, 32'd0, 32'hDEAD, 2'b00);
        drive("clear", 4'hC, 32'd0, 32'd9, 32'd0, 2'b00);
        drive("mulOvf", 4'h3, 32'd3000, 32'd25765623, 32'd4282424968, 2'b01);
        drive("mulOk", 4'h3, 32'd1000, 32'd1000, 32'd1000000, 2'b00);
        drive("addCarry", 4'h1, 32'hFFFFFFFF, 32'd1, 32'd0, 2'b01);
        drive("subWrap", 4'h2, 32'd5, 32'd7, 32'hFFFFFFFE, 2'b01);
        drive("subOk", 4'h2, 32'd7, 32'd5, 32'd2, 2'b00);
        drive("div", 4'h4, 32'd100, 32'd7, 32'd14, 2'b00);
        drive("mod", 4'h5, 32'd100, 32'd7, 32'd2, 2'b00);
        drive("divZero", 4'h4, 32'd100, 32'd0, 32'd0, 2'b10);
        drive("modZero", 4'h5, 32'd100, 32'd0, 32'd0, 2'b10);
        drive("and", 4'h6, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 2'b00);
        drive("or", 4'h7, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 2'b00);
        drive("xor", 4'h8, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 2'b00);
        drive("not", 4'h9, 32'hF0F0F0F0, 32'h12345678, 32'h0F0F0F0F, 2'b00);
        drive("shl", 4'hA, 32'd1, 32'd36, 32'h10, 2'b00);
        drive("shr", 4'hB, 32'h80000000, 32'd33, 32'h40000000, 2'b00);
        drive("load", 4'hD, 32'h1234, 32'd0, 32'h1234, 2'b00);
        drive("nop", 4'h0, 32'hAAAA, 32'hBBBB, 32'h1234, 2'b00);
        drive("ill14", 4'hE, 32'hAAAA, 32'hBBBB, 32'h1234, 2'b11);
        drive("ill15", 4'hF, 32'hAAAA, 32'hBBBB, 32'h1234, 2'b11);
        drive("nopClr", 4'h0, 32'd0, 32'd0, 32'h1234, 2'b00);
        drive("clear2", 4'hC, 32'h5555, 32'd0, 32'd0, 2'b00);
        for (int i = 0; i < 16; i++) begin
            p = $urandom;
            q = (i % 4 == 0) ? ~p + 32'd1 + 32'(i) : $urandom;
            if (i % 2 == 0) drive("rndAdd", 4'h1, p, q, p + q, {1'b0, (p + q) < p});
            else drive("rndSub", 4'h2, p, q, p - q, {1'b0, p < q});
        end
        drive("load77", 4'hD, 32'h77, 32'd0, 32'h77, 2'b00);
        @(negedge clk);
        bus.inputP = 32'h99;
        #2;
        check("midChange.out", bus.outALU, 32'h77);
        bus.opCode = 4'h1;
        bus.inputP = 32'd1;
        bus.inputQ = 32'd2;
        #1 rst_n = 1'b0;
        #1;
        check("asyncRst.out", bus.outALU, 32'd0);
        check("asyncRst.err", {30'd0, bus.errorCode}, 32'd0);
        @(posedge clk);
        #1;
        check("rstEdge.out", bus.outALU, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        expQ.push_back({32'd3, 2'b00});
        @(posedge clk);
        #1;
        popCheck("afterRst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu.md
# alu

Registered 32-bit unsigned arithmetic/logic unit used by the calculator datapath. Each rising clock edge computes one operation selected by `opCode` on operands `inputP`/`inputQ`. The block captures the result and a 2-bit status into output registers. The host middleware drives the operands and opcode, then reads `outALU` and `errorCode` one cycle later.

## Interface
- No parameters; data width fixed at 32 bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `inputP`  input  32  operand P (unsigned).
- `inputQ`  input  32  operand Q (unsigned).
- `opCode`  input  4  operation select.
- `outALU`  output  32  registered result.
- `errorCode`  output  2  registered status: 00 ok, 01 overflow/underflow, 10 divide-by-zero, 11 illegal opcode.

## Operation
- All arithmetic is unsigned, 32-bit. The result is always the low 32 bits of the exact result.
- Opcode map:
  - 0000 NOP: hold `outALU`; `errorCode` <= 00.
  - 0001 ADD: P+Q; error 01 on carry out of bit 31.
  - 0010 SUB: P-Q; error 01 if P<Q (result wraps).
  - 0011 MUL: low 32 bits of the 64-bit product P*Q; error 01 if the upper 32 bits are nonzero.
  - 0100 DIV: P/Q, truncating. If Q=0: result 0, error 10.
  - 0101 MOD: P%Q. If Q=0: result 0, error 10.
  - 0110 AND, 0111 OR, 1000 XOR: bitwise P op Q; error 00.
  - 1001 NOT: ~P; Q ignored; error 00.
  - 1010 SHL: P << Q[4:0]; error 00. Q[31:5] ignored.
  - 1011 SHR: logical shift P >> Q[4:0]; error 00.
  - 1100 CLEAR: `outALU` <= 0, `errorCode` <= 00. This is the synchronous soft reset the host issues before a calculation.
  - 1101 LOAD: `outALU` <= P; error 00.
  - 1110, 1111 reserved: hold `outALU`; error 11.
- The error code is purely per-operation; it is not sticky. Each edge overwrites it with the status of the current opcode.
- The combinational result path is fully decoded. Unused opcodes never produce X on outputs.

## Timing
- `rst_n` low asynchronously forces `outALU`=0 and `errorCode`=00 immediately, regardless of `clk`. The outputs stay there while `rst_n` is low.
- After `rst_n` rises, the first rising `clk` edge performs the operation then presented.
- Latency is 1 cycle. Inputs are sampled at rising edge N; results are visible after edge N and stable until edge N+1.
- There is no handshake and no valid signal. A new operation is accepted every cycle; the multiplier and divider are single-cycle combinational.
- Inputs changing between edges have no effect on the outputs until the next edge.
- Reset asserted mid-operation discards the pending result; no partial state survives.
- CLEAR (1100) and `rst_n` produce identical output values. CLEAR is synchronous; `rst_n` is asynchronous.

## Test plan
- Reset: drive `rst_n`=0 with arbitrary inputs -> `outALU`=0, `errorCode`=00 without waiting for a clock edge.
- CLEAR then MUL:
  - P=0, opCode=1100 for one edge -> `outALU`=0.
  - Then P=3000, Q=25765623, opCode=0011 -> after the next edge, `outALU`=4282424968 and `errorCode`=01.
- ADD/SUB boundaries:
  - P=0xFFFFFFFF, Q=1, ADD -> 0, error 01.
  - P=5, Q=7, SUB -> 0xFFFFFFFE, error 01.
  - P=7, Q=5, SUB -> 2, error 00.
- DIV/MOD:
  - P=100, Q=7 -> DIV 14, MOD 2, error 00.
  - Q=0 -> `outALU`=0, error 10.
- Logic/shift:
  - P=0xF0F0F0F0, Q=0x0FF00FF0 -> AND 0x00F000F0, OR 0xFFF0FFF0, XOR 0xFF00FF00.
  - NOT P -> 0x0F0F0F0F.
  - SHL P=1, Q=36 -> 0x10, since the shift amount is Q[4:0]=4.
- Hold/illegal:
  - After LOAD P=0x1234, NOP -> `outALU` stays 0x1234, error 00.
  - Opcode 1110 -> `outALU` stays 0x1234, error 11.
